// File: rtl/rdmx_frame_seq_if.sv
// ============================================================================
//  Module      : rdmx_frame_seq_if
//  Description : Slot-offer and frame-counter-write handshake bundle between
//                the RDMX frame-slot sequencer and the shim datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rdmx_frame_seq_if;
  logic [63:0] SLOT_FRAME_ADDR;
  logic [63:0] SLOT_META_ADDR;
  logic        SLOT_VALID;
  logic        SLOT_READY;
  logic        frame_done;
  logic [63:0] FC_ADDR;
  logic [63:0] FC_DATA;
  logic        FC_VALID;
  logic        FC_READY;

  // Sequencer side
  modport master (
    output SLOT_FRAME_ADDR, SLOT_META_ADDR, SLOT_VALID,
    input  SLOT_READY, frame_done,
    output FC_ADDR, FC_DATA, FC_VALID,
    input  FC_READY
  );

  // Shim side
  modport slave (
    input  SLOT_FRAME_ADDR, SLOT_META_ADDR, SLOT_VALID,
    output SLOT_READY, frame_done,
    input  FC_ADDR, FC_DATA, FC_VALID,
    output FC_READY
  );
endinterface

`default_nettype wire

// File: rtl/rdmx_frame_seq.sv
// ============================================================================
//  Module      : rdmx_frame_seq
//  Description : Frame-slot sequencer. Offers one frame slot and one metadata
//                slot at a time, walks both rings with wrap-around, and posts
//                a 64-bit frame-counter write after every completed frame.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rdmx_frame_seq #(
  parameter logic [63:0] FRAME_SIZE = 64'h1000,
  parameter logic [63:0] META_SIZE  = 64'h40
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [63:0] RFD_ADDR,
  input  logic [63:0] RFD_SIZE,
  input  logic [63:0] RMD_ADDR,
  input  logic [63:0] RMD_SIZE,
  input  logic [63:0] RFC_ADDR,
  input  logic        start,
  input  logic        stop,
  output logic        running,
  output logic        cfg_error,
  output logic [63:0] frame_count,
  rdmx_frame_seq_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    BUSY   = 2'd2,
    REPORT = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;

  logic [63:0] r_rfd_base, w_rfd_base_nxt;
  logic [63:0] r_rfd_size, w_rfd_size_nxt;
  logic [63:0] r_rmd_base, w_rmd_base_nxt;
  logic [63:0] r_rmd_size, w_rmd_size_nxt;
  logic [63:0] r_rfc_addr, w_rfc_addr_nxt;
  logic [63:0] r_frame_ptr, w_frame_ptr_nxt;
  logic [63:0] r_meta_ptr, w_meta_ptr_nxt;
  logic [63:0] r_count, w_count_nxt;
  logic [63:0] r_fc_addr, w_fc_addr_nxt;
  logic [63:0] r_fc_data, w_fc_data_nxt;
  logic        r_stop_pending, w_stop_pending_nxt;
  logic        r_cfg_error, w_cfg_error_nxt;
  logic        r_slot_valid, r_fc_valid, r_running;

  // Next slot in a ring; the limit test is done with headroom bits so that
  // a ring ending exactly at 2^64 still wraps correctly.
  function automatic logic [63:0] f_wrap(input logic [63:0] ptr,
                                         input logic [63:0] base,
                                         input logic [63:0] size,
                                         input logic [63:0] step);
    logic [65:0] nxt;
    logic [65:0] lim;
    nxt = {2'b00, ptr} + {2'b00, step};
    lim = {2'b00, base} + {2'b00, size};
    if ((nxt + {2'b00, step}) > lim) return base;
    return nxt[63:0];
  endfunction

  // Next-state and datapath update decisions
  always_comb begin
    w_state_nxt        = r_state;
    w_rfd_base_nxt     = r_rfd_base;
    w_rfd_size_nxt     = r_rfd_size;
    w_rmd_base_nxt     = r_rmd_base;
    w_rmd_size_nxt     = r_rmd_size;
    w_rfc_addr_nxt     = r_rfc_addr;
    w_frame_ptr_nxt    = r_frame_ptr;
    w_meta_ptr_nxt     = r_meta_ptr;
    w_count_nxt        = r_count;
    w_fc_addr_nxt      = r_fc_addr;
    w_fc_data_nxt      = r_fc_data;
    w_stop_pending_nxt = r_stop_pending;
    w_cfg_error_nxt    = r_cfg_error;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_rfd_base_nxt = RFD_ADDR;
          w_rfd_size_nxt = RFD_SIZE;
          w_rmd_base_nxt = RMD_ADDR;
          w_rmd_size_nxt = RMD_SIZE;
          w_rfc_addr_nxt = RFC_ADDR;
          if ((RFD_SIZE < FRAME_SIZE) || (RMD_SIZE < META_SIZE)) begin
            w_cfg_error_nxt = 1'b1;
          end else begin
            w_cfg_error_nxt    = 1'b0;
            w_frame_ptr_nxt    = RFD_ADDR;
            w_meta_ptr_nxt     = RMD_ADDR;
            w_count_nxt        = 64'd0;
            w_stop_pending_nxt = 1'b0;
            w_state_nxt        = ISSUE;
          end
        end
      end
      ISSUE: begin
        // An accepted slot always wins over a simultaneous stop.
        if (bus.SLOT_READY) begin
          w_stop_pending_nxt = r_stop_pending | stop;
          w_state_nxt        = BUSY;
        end else if (stop) begin
          w_state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (stop) w_stop_pending_nxt = 1'b1;
        if (bus.frame_done) begin
          w_count_nxt     = r_count + 64'd1;
          w_fc_data_nxt   = r_count + 64'd1;
          w_fc_addr_nxt   = r_rfc_addr;
          w_frame_ptr_nxt = f_wrap(r_frame_ptr, r_rfd_base, r_rfd_size, FRAME_SIZE);
          w_meta_ptr_nxt  = f_wrap(r_meta_ptr, r_rmd_base, r_rmd_size, META_SIZE);
          w_state_nxt     = REPORT;
        end
      end
      REPORT: begin
        if (bus.FC_READY) begin
          w_state_nxt = (r_stop_pending || stop) ? IDLE : ISSUE;
        end else if (stop) begin
          w_stop_pending_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state        <= IDLE;
      r_rfd_base     <= '0;
      r_rfd_size     <= '0;
      r_rmd_base     <= '0;
      r_rmd_size     <= '0;
      r_rfc_addr     <= '0;
      r_frame_ptr    <= '0;
      r_meta_ptr     <= '0;
      r_count        <= '0;
      r_fc_addr      <= '0;
      r_fc_data      <= '0;
      r_stop_pending <= 1'b0;
      r_cfg_error    <= 1'b0;
      r_slot_valid   <= 1'b0;
      r_fc_valid     <= 1'b0;
      r_running      <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_rfd_base     <= w_rfd_base_nxt;
      r_rfd_size     <= w_rfd_size_nxt;
      r_rmd_base     <= w_rmd_base_nxt;
      r_rmd_size     <= w_rmd_size_nxt;
      r_rfc_addr     <= w_rfc_addr_nxt;
      r_frame_ptr    <= w_frame_ptr_nxt;
      r_meta_ptr     <= w_meta_ptr_nxt;
      r_count        <= w_count_nxt;
      r_fc_addr      <= w_fc_addr_nxt;
      r_fc_data      <= w_fc_data_nxt;
      r_stop_pending <= w_stop_pending_nxt;
      r_cfg_error    <= w_cfg_error_nxt;
      r_slot_valid   <= (w_state_nxt == ISSUE);
      r_fc_valid     <= (w_state_nxt == REPORT);
      r_running      <= (w_state_nxt != IDLE);
    end
  end

  assign running             = r_running;
  assign cfg_error           = r_cfg_error;
  assign frame_count         = r_count;
  assign bus.SLOT_VALID      = r_slot_valid;
  assign bus.SLOT_FRAME_ADDR = r_frame_ptr;
  assign bus.SLOT_META_ADDR  = r_meta_ptr;
  assign bus.FC_VALID        = r_fc_valid;
  assign bus.FC_ADDR         = r_fc_addr;
  assign bus.FC_DATA         = r_fc_data;

endmodule

`default_nettype wire
